// File: rtl/fetch_jump_controller_pkg.sv
// Shared constants and types for the accumulator processor fetch/jump sequencer.
package fetch_jump_controller_pkg;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] PC_INC   = 16'd2;

  localparam logic [2:0] OPC_JUMP = 3'b111;
  localparam logic [2:0] OPC_JZ   = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b000;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 13;
  localparam int unsigned IMM_MSB = 12;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StHalted
  } state_e;

  function automatic logic [2:0] get_opcode(input logic [15:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_jump_controller_jump_target_gen.sv
// Jump target former: keeps the PC page bits and places the word-aligned immediate below them.
module jump_target_gen (
  input  logic [1:0]  i_pc_hi,
  input  logic [12:0] i_imm13,
  output logic [15:0] o_target
);

  assign o_target = {i_pc_hi, i_imm13, 1'b0};

endmodule

// File: rtl/fetch_jump_controller.sv
// Fetch/decode sequencer: owns PC and IR, resolves JUMP/JZ locally and hands other
// instructions to the execute unit through a start/done handshake.
module fetch_jump_controller
  import fetch_jump_controller_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_run,
  output logic        o_mem_req,
  output logic [15:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [15:0] i_mem_rdata,
  input  logic        i_acc_zero,
  output logic        o_exec_start,
  input  logic        i_exec_done,
  output logic [15:0] o_pc,
  output logic [15:0] o_ir,
  output logic        o_jump_taken,
  output logic        o_halted,
  output logic        o_busy
);

  state_e      r_state, w_state_next;
  logic [15:0] r_pc, w_pc_next;
  logic [15:0] r_ir, w_ir_next;
  logic        r_exec_start, w_exec_start_next;
  logic        r_jump_taken, w_jump_taken_next;
  logic        r_halted, w_halted_next;
  logic        r_busy, w_busy_next;
  logic [15:0] w_target;
  logic [2:0]  w_opcode;

  // r_pc is already post-increment in DECODE, so the page bits come from the next word.
  jump_target_gen u_jump_target_gen (
    .i_pc_hi  (r_pc[15:14]),
    .i_imm13  (r_ir[IMM_MSB:IMM_LSB]),
    .o_target (w_target)
  );

  assign w_opcode = get_opcode(r_ir);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_pc         <= RESET_PC;
      r_ir         <= 16'h0000;
      r_exec_start <= 1'b0;
      r_jump_taken <= 1'b0;
      r_halted     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_ir         <= w_ir_next;
      r_exec_start <= w_exec_start_next;
      r_jump_taken <= w_jump_taken_next;
      r_halted     <= w_halted_next;
      r_busy       <= w_busy_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_ir_next         = r_ir;
    w_exec_start_next = 1'b0;
    w_jump_taken_next = 1'b0;

    case (r_state)
      StIdle: begin
        if (i_run) w_state_next = StFetch;
      end
      StFetch: begin
        if (i_mem_ack) begin
          w_ir_next    = i_mem_rdata;
          w_pc_next    = r_pc + PC_INC;
          w_state_next = StDecode;
        end
      end
      StDecode: begin
        case (w_opcode)
          OPC_JUMP: begin
            w_pc_next         = w_target;
            w_jump_taken_next = 1'b1;
            w_state_next      = i_run ? StFetch : StIdle;
          end
          OPC_JZ: begin
            if (i_acc_zero) begin
              w_pc_next         = w_target;
              w_jump_taken_next = 1'b1;
            end
            w_state_next = i_run ? StFetch : StIdle;
          end
          OPC_HALT: begin
            w_state_next = StHalted;
          end
          default: begin
            w_exec_start_next = 1'b1;
            w_state_next      = StExec;
          end
        endcase
      end
      StExec: begin
        if (i_exec_done) w_state_next = i_run ? StFetch : StIdle;
      end
      StHalted: begin
        w_state_next = StHalted;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase

    w_halted_next = (w_state_next == StHalted);
    w_busy_next   = (w_state_next != StIdle) && (w_state_next != StHalted);
  end

  assign o_mem_req    = (r_state == StFetch);
  assign o_mem_addr   = r_pc;
  assign o_pc         = r_pc;
  assign o_ir         = r_ir;
  assign o_exec_start = r_exec_start;
  assign o_jump_taken = r_jump_taken;
  assign o_halted     = r_halted;
  assign o_busy       = r_busy;

endmodule

// File: doc/fetch_jump_controller.md
# fetch_jump_controller

Sequencer for the accumulator processor's instruction fetch and program-counter update path. Owns PC and IR, fetches instructions over a request/acknowledge memory port, and resolves unconditional and zero-conditional jumps itself. Forms jump targets by concatenating the upper PC bits with the left-shifted IR immediate. Hands all other instructions to the execute unit through a start/done handshake. Sits between instruction memory, the PC/IR datapath and the accumulator execute unit.

## Interface
- RESET_PC, 16'h0000: PC value loaded on reset.
- OPC_JUMP, 3'b111: unconditional jump opcode.
- OPC_JZ, 3'b110: jump-if-accumulator-zero opcode.
- OPC_HALT, 3'b000: halt opcode.
- CLK  in  1  single clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high; forces the reset state immediately.
- Run  in  1  level; enables instruction sequencing.
- MemReq  out  1  fetch request.
- MemAddr  out  16  fetch address; equals PC.
- MemAck  in  1  fetch data valid this cycle.
- MemRdata  in  16  instruction word.
- AccZero  in  1  accumulator == 0, from execute unit.
- ExecStart  out  1  one-cycle pulse: execute IR.
- ExecDone  in  1  execute unit finished.
- PC  out  16  program counter.
- IR  out  16  instruction register.
- JumpTaken  out  1  one-cycle pulse when PC is loaded with a jump target.
- Halted  out  1  high while in HALTED.
- Busy  out  1  high in any state except IDLE and HALTED.

## Operation
- Instruction format: opcode = IR[15:13]; imm13 = IR[12:0].
- Jump target = {PC[15:14], imm13, 1'b0}. PC is already incremented when the target is formed.
- PC increment is +2, modulo 2^16: 16'hFFFE → 16'h0000.
- States: IDLE, FETCH, DECODE, EXEC, HALTED.
- IDLE: if Run=1 → FETCH.
- FETCH: MemReq=1, MemAddr=PC.
  - On MemAck=1: IR←MemRdata, PC←PC+2, → DECODE.
  - MemAck is ignored in every other state.
- DECODE:
  - OPC_JUMP: PC←target, JumpTaken=1.
  - OPC_JZ with AccZero=1: PC←target, JumpTaken=1.
  - OPC_JZ with AccZero=0: PC unchanged.
  - For all three cases, next state is FETCH if Run=1, otherwise IDLE.
  - OPC_HALT → HALTED.
  - Any other opcode → EXEC; ExecStart=1 on the first EXEC cycle.
- EXEC: on ExecDone=1, → FETCH if Run=1, otherwise IDLE. ExecDone is sampled in every EXEC cycle, including the ExecStart cycle.
- HALTED: terminal; left only by Reset.
- Run deasserted mid-instruction: the current instruction completes; the controller stops at the next FETCH boundary and enters IDLE. A FETCH already in progress keeps MemReq high until MemAck.
- Reset mid-fetch or mid-exec: instruction abandoned, no PC/IR update. Outputs return to reset values asynchronously.
- Reset values: state IDLE, PC=RESET_PC, IR=16'h0000, MemReq=0, MemAddr=RESET_PC, ExecStart=0, JumpTaken=0, Halted=0, Busy=0.

## Timing
- MemReq and MemAddr are combinational from state and PC. All other outputs are registered.
- MemReq holds until MemAck. Minimum fetch is one cycle (MemAck in the first FETCH cycle).
- Jump, minimum: FETCH 1 + DECODE 1 = 2 cycles from request to the next MemReq with the new PC.
- Executed instruction, minimum: FETCH 1 + DECODE 1 + EXEC 1 = 3 cycles.
- AccZero is sampled in the DECODE cycle only.
- JumpTaken and ExecStart are exactly one cycle wide and are never asserted together.
- IDLE→FETCH: MemReq asserts in the cycle after Run is sampled high.

## Structure
- Shared package (processor constants): opcode constants OPC_JUMP/OPC_JZ/OPC_HALT, state encodings, PC increment constant 2, field positions of opcode and imm13.
- One sub-module: jump_target_gen, combinational. Inputs: PC[15:14] and IR[12:0]. Output: 16-bit target.
- FSM, PC and IR registers stay in fetch_jump_controller.
- Target size: about 150–250 lines of RTL.

## Test plan
- Reset, Run=1, memory at 0x0000 returns 16'h2005 with MemAck after 2 wait cycles, ExecDone 3 cycles after ExecStart:
  - IR=16'h2005, PC=0x0002.
  - Exactly one ExecStart pulse.
  - Next MemAddr=0x0002.
- Jump address base: PC=0x3FFE fetches 16'hE010 (OPC_JUMP, imm=0x0010).
  - After the increment PC=0x4000, so the target is 0x4020.
  - JumpTaken pulses once; next MemAddr=0x4020.
- OPC_JZ 16'hC008 with AccZero=1 → PC=target 0x0010. Same word with AccZero=0 → PC stays at fall-through, no JumpTaken.
- Wrap: PC=0xFFFE fetches a non-jump → PC=0x0000 after fetch.
- OPC_HALT 16'h0000 → Halted=1, Busy=0, no further MemReq for 20 cycles with Run=1 held.
- Reset asserted during FETCH wait and during EXEC:
  - Immediate PC=RESET_PC, IR=0, MemReq=0.
  - Sequencing restarts cleanly after release.
  - Run dropped during EXEC → instruction completes, then IDLE with no new MemReq.
